// File: rtl/dft_mode_sequencer_pkg.sv
// Shared definitions for the DFT mode sequencer: mode encodings, FSM states
// and small elaboration-time helpers.
package dft_mode_sequencer_pkg;

    // Clock mode encodings; mode 0 is the functional clock.
    localparam int MODE_FUNCTIONAL = 0;
    localparam int MODE_SCAN       = 1;
    localparam int MODE_JTAG       = 2;
    localparam int MODE_BIST       = 3;

    // Switch sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        BREAK  = 2'd2,
        SETTLE = 2'd3
    } seq_state_e;

    // Largest of the three phase lengths; sizes the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold n-1 (the counter is loaded with N-1), at least one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dft_mode_sequencer_sync_chain.sv
// Generic multi-flop synchroniser for a single asynchronous level signal.
module dft_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through STAGES flops; output is the last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dft_mode_sequencer.sv
// Break-before-make clock mode sequencer: gates the core clock enable, drops
// the one-hot select for a break window, applies the new select, lets it
// settle, then re-enables. Also synchronises scan_enable into func_clk.
module dft_mode_sequencer
    import dft_mode_sequencer_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = $clog2(NUM_MODES),
    parameter int GATE_CYC    = 2,
    parameter int BBM_CYC     = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 func_clk,
    input  logic                 rst_n,
    input  logic [MODE_W-1:0]    mode_req,
    input  logic                 mode_req_valid,
    output logic                 mode_req_ready,
    input  logic                 dft_bypass,
    input  logic                 scan_enable,
    output logic [NUM_MODES-1:0] mode_sel,
    output logic [MODE_W-1:0]    mode_cur,
    output logic                 clk_en,
    output logic                 switch_busy,
    output logic                 switch_done,
    output logic                 err_illegal,
    output logic                 is_test_mode,
    output logic                 scan_en_sync
);

    localparam int CNT_W = cnt_width(max3(GATE_CYC, BBM_CYC, SETTLE_CYC));
    localparam logic [MODE_W:0] NUM_MODES_EXT = (MODE_W+1)'(NUM_MODES);
    localparam logic [NUM_MODES-1:0] SEL_MODE0 = NUM_MODES'(1);

    seq_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [MODE_W-1:0]     target_q;
    logic [MODE_W-1:0]     mode_cur_q;
    logic [NUM_MODES-1:0]  mode_sel_q;
    logic                  clk_en_q;
    logic                  done_q;
    logic                  err_q;

    logic                  accept;
    logic                  illegal;
    logic [MODE_W-1:0]     target_d;

    // One-hot select for a (legal) mode index.
    function automatic logic [NUM_MODES-1:0] onehot(input logic [MODE_W-1:0] idx);
        return SEL_MODE0 << idx;
    endfunction

    // Requests are only looked at while idle; bypass overrides to functional.
    assign accept   = mode_req_valid & (state_q == IDLE);
    assign target_d = dft_bypass ? MODE_W'(MODE_FUNCTIONAL) : mode_req;
    assign illegal  = ~dft_bypass & ({1'b0, mode_req} >= NUM_MODES_EXT);

    // Switch sequencer: IDLE -> GATE -> BREAK -> SETTLE -> IDLE, one shared
    // down-counter loaded with N-1 on entry to each timed phase.
    always_ff @(posedge func_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            mode_cur_q <= MODE_W'(MODE_FUNCTIONAL);
            mode_sel_q <= SEL_MODE0;
            clk_en_q   <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            // Out-of-range target: flag it, touch nothing else.
                            err_q <= 1'b1;
                        end else if (target_d == mode_cur_q) begin
                            // Already there: acknowledge without gating.
                            done_q <= 1'b1;
                        end else begin
                            target_q <= target_d;
                            clk_en_q <= 1'b0;
                            cnt_q    <= CNT_W'(GATE_CYC - 1);
                            state_q  <= GATE;
                        end
                    end
                end
                GATE: begin
                    // Clock enable already low; old select still applied.
                    if (cnt_q == '0) begin
                        mode_sel_q <= '0;
                        cnt_q      <= CNT_W'(BBM_CYC - 1);
                        state_q    <= BREAK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BREAK: begin
                    // No source selected; commit the new mode on exit.
                    if (cnt_q == '0) begin
                        mode_sel_q <= onehot(target_q);
                        mode_cur_q <= target_q;
                        cnt_q      <= CNT_W'(SETTLE_CYC - 1);
                        state_q    <= SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    // New select applied; release the clock once it is stable.
                    if (cnt_q == '0) begin
                        clk_en_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mode_req_ready = (state_q == IDLE);
    assign switch_busy    = (state_q != IDLE);
    assign mode_sel       = mode_sel_q;
    assign mode_cur       = mode_cur_q;
    assign clk_en         = clk_en_q;
    assign switch_done    = done_q;
    assign err_illegal    = err_q;
    assign is_test_mode   = (mode_cur_q != MODE_W'(MODE_FUNCTIONAL));

    dft_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_scan_sync (
        .clk_i  (func_clk),
        .rst_ni (rst_n),
        .d_i    (scan_enable),
        .q_o    (scan_en_sync)
    );

endmodule

// File: tb/tb_dft_mode_sequencer.sv
// Directed bench: dut_a uses default timing with a 3-deep scan synchroniser,
// dut_b uses NUM_MODES=3 so an out-of-range index is representable.
module tb_dft_mode_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    // dut_a signals
    logic [1:0] mode_req;
    logic       mode_req_valid, dft_bypass, scan_enable;
    logic       mode_req_ready, clk_en, switch_busy, switch_done;
    logic       err_illegal, is_test_mode, scan_en_sync;
    logic [3:0] mode_sel;
    logic [1:0] mode_cur;

    // dut_b signals
    logic [1:0] b_mode_req;
    logic       b_valid, b_bypass, b_scan;
    logic       b_ready, b_clk_en, b_busy, b_done, b_err, b_test, b_sync;
    logic [2:0] b_sel;
    logic [1:0] b_cur;

    always #5 clk = ~clk;

    dft_mode_sequencer #(.NUM_MODES(4), .SYNC_STAGES(3)) dut_a (
        .func_clk(clk), .rst_n(rst_n), .mode_req(mode_req),
        .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
        .dft_bypass(dft_bypass), .scan_enable(scan_enable), .mode_sel(mode_sel),
        .mode_cur(mode_cur), .clk_en(clk_en), .switch_busy(switch_busy),
        .switch_done(switch_done), .err_illegal(err_illegal),
        .is_test_mode(is_test_mode), .scan_en_sync(scan_en_sync)
    );

    dft_mode_sequencer #(.NUM_MODES(3)) dut_b (
        .func_clk(clk), .rst_n(rst_n), .mode_req(b_mode_req),
        .mode_req_valid(b_valid), .mode_req_ready(b_ready),
        .dft_bypass(b_bypass), .scan_enable(b_scan), .mode_sel(b_sel),
        .mode_cur(b_cur), .clk_en(b_clk_en), .switch_busy(b_busy),
        .switch_done(b_done), .err_illegal(b_err),
        .is_test_mode(b_test), .scan_en_sync(b_sync)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full switch from the current mode; k counts cycles after acceptance.
    task automatic run_switch(input logic [1:0] req, input logic byp,
                              input logic [3:0] sel_old, input logic [3:0] sel_new,
                              input logic [1:0] cur_new, input string tag);
        logic [3:0] exp_sel;
        mode_req = req; dft_bypass = byp; mode_req_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            mode_req_valid = 1'b0; dft_bypass = 1'b0;
            exp_sel = (k <= 2) ? sel_old : (k <= 4) ? 4'b0000 : sel_new;
            chk($sformatf("%s clk_en k=%0d", tag, k), 32'(clk_en), 32'(k == 9));
            chk($sformatf("%s sel k=%0d", tag, k), 32'(mode_sel), 32'(exp_sel));
            chk($sformatf("%s done k=%0d", tag, k), 32'(switch_done), 32'(k == 9));
            chk($sformatf("%s busy k=%0d", tag, k), 32'(switch_busy), 32'(k != 9));
            if (k >= 5) chk($sformatf("%s cur k=%0d", tag, k), 32'(mode_cur), 32'(cur_new));
        end
    endtask

    initial begin
        logic [3:0] exp_sel;
        rst_n = 1'b1;
        mode_req = 2'd0; mode_req_valid = 1'b0; dft_bypass = 1'b0; scan_enable = 1'b0;
        b_mode_req = 2'd0; b_valid = 1'b0; b_bypass = 1'b0; b_scan = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst sel", 32'(mode_sel), 32'h1);
        chk("rst cur", 32'(mode_cur), 32'h0);
        chk("rst clk_en", 32'(clk_en), 32'h1);
        chk("rst busy", 32'(switch_busy), 32'h0);
        chk("rst done", 32'(switch_done), 32'h0);
        chk("rst err", 32'(err_illegal), 32'h0);
        chk("rst sync", 32'(scan_en_sync), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle sel", 32'(mode_sel), 32'h1);
        chk("idle cur", 32'(mode_cur), 32'h0);
        chk("idle clk_en", 32'(clk_en), 32'h1);
        chk("idle ready", 32'(mode_req_ready), 32'h1);
        chk("idle test", 32'(is_test_mode), 32'h0);

        // Mode 0 -> 2.
        run_switch(2'd2, 1'b0, 4'b0001, 4'b0100, 2'd2, "sw2");
        chk("sw2 test", 32'(is_test_mode), 32'h1);
        chk("sw2 ready", 32'(mode_req_ready), 32'h1);
        step();
        chk("sw2 done clr", 32'(switch_done), 32'h0);

        // Bypass forces mode 0 regardless of mode_req.
        run_switch(2'd3, 1'b1, 4'b0100, 4'b0001, 2'd0, "byp");
        chk("byp test", 32'(is_test_mode), 32'h0);

        // Go to mode 1, then request mode 1 again.
        run_switch(2'd1, 1'b0, 4'b0001, 4'b0010, 2'd1, "sw1");
        step();
        mode_req = 2'd1; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        chk("same done", 32'(switch_done), 32'h1);
        chk("same busy", 32'(switch_busy), 32'h0);
        chk("same clk_en", 32'(clk_en), 32'h1);
        chk("same sel", 32'(mode_sel), 32'h2);
        step();
        chk("same done clr", 32'(switch_done), 32'h0);
        chk("same clk_en2", 32'(clk_en), 32'h1);

        // Illegal index on the 3-mode instance.
        b_mode_req = 2'd3; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        chk("ill err", 32'(b_err), 32'h1);
        chk("ill busy", 32'(b_busy), 32'h0);
        chk("ill sel", 32'(b_sel), 32'h1);
        chk("ill clk_en", 32'(b_clk_en), 32'h1);
        chk("ill cur", 32'(b_cur), 32'h0);
        chk("ill done", 32'(b_done), 32'h0);
        step();
        chk("ill err clr", 32'(b_err), 32'h0);
        // Same index with bypass is mode 0, already current.
        b_mode_req = 2'd3; b_bypass = 1'b1; b_valid = 1'b1;
        step();
        b_valid = 1'b0; b_bypass = 1'b0;
        chk("illbyp err", 32'(b_err), 32'h0);
        chk("illbyp done", 32'(b_done), 32'h1);

        // Reset in the middle of BREAK.
        mode_req = 2'd3; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        step();
        step();
        chk("brk sel", 32'(mode_sel), 32'h0);
        chk("brk busy", 32'(switch_busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort sel", 32'(mode_sel), 32'h1);
        chk("abort clk_en", 32'(clk_en), 32'h1);
        chk("abort busy", 32'(switch_busy), 32'h0);
        chk("abort cur", 32'(mode_cur), 32'h0);
        rst_n = 1'b1;

        // Valid held through a switch is taken only when ready returns.
        mode_req = 2'd2; mode_req_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) mode_req = 2'd3;
            exp_sel = (k <= 2) ? 4'b0001 : (k <= 4) ? 4'b0000 : 4'b0100;
            chk($sformatf("held sel k=%0d", k), 32'(mode_sel), 32'(exp_sel));
            chk($sformatf("held ready k=%0d", k), 32'(mode_req_ready), 32'(k == 9));
        end
        chk("held done", 32'(switch_done), 32'h1);
        step();
        mode_req_valid = 1'b0;
        chk("held2 busy", 32'(switch_busy), 32'h1);
        chk("held2 clk_en", 32'(clk_en), 32'h0);
        chk("held2 sel", 32'(mode_sel), 32'h4);
        repeat (8) step();
        chk("held2 fin sel", 32'(mode_sel), 32'h8);
        chk("held2 fin cur", 32'(mode_cur), 32'h3);
        chk("held2 fin done", 32'(switch_done), 32'h1);
        chk("held2 fin clk_en", 32'(clk_en), 32'h1);

        // scan_enable through the 3-deep synchroniser.
        scan_enable = 1'b1;
        step();
        chk("sync e1", 32'(scan_en_sync), 32'h0);
        step();
        chk("sync e2", 32'(scan_en_sync), 32'h0);
        step();
        chk("sync e3", 32'(scan_en_sync), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
